// File: rtl/risc_pipe_pkg.sv
// Shared pipeline encodings: writeback sources, load funct3 codes, exception codes, M2 state.
package risc_pipe_pkg;

  localparam logic [2:0] WB_NONE = 3'd0;
  localparam logic [2:0] WB_ALU  = 3'd1;
  localparam logic [2:0] WB_LOAD = 3'd2;
  localparam logic [2:0] WB_PC4  = 3'd3;
  localparam logic [2:0] WB_CSR  = 3'd4;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;

  localparam logic [1:0] EXC_NONE  = 2'd0;
  localparam logic [1:0] EXC_MIS   = 2'd1;
  localparam logic [1:0] EXC_FAULT = 2'd2;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_DRAIN} m2_state_t;

endpackage

// File: rtl/m2_stage_if.sv
// M1->M2 register outputs, data-memory load response and M2->WB / hazard-unit outputs.
interface m2_stage_if;
  logic [31:0] result;
  logic [4:0]  rd;
  logic [2:0]  wb_src;
  logic [31:0] pc;
  logic [4:0]  mem_op;
  logic [15:0] csr_op;
  logic [31:0] csr_dataout;
  logic [31:0] csr_result;
  logic        flush;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        dmem_rerr;

  logic        stall;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [15:0] wb_csr_op;
  logic [31:0] wb_csr_result;
  logic [1:0]  wb_exc;

  modport slave (
    input  result, rd, wb_src, pc, mem_op, csr_op, csr_dataout, csr_result, flush,
           dmem_rvalid, dmem_rdata, dmem_rerr,
    output stall, fwd_valid, fwd_rd, fwd_data, wb_valid, wb_we, wb_rd, wb_data, wb_pc,
           wb_csr_op, wb_csr_result, wb_exc
  );

  modport master (
    output result, rd, wb_src, pc, mem_op, csr_op, csr_dataout, csr_result, flush,
           dmem_rvalid, dmem_rdata, dmem_rerr,
    input  stall, fwd_valid, fwd_rd, fwd_data, wb_valid, wb_we, wb_rd, wb_data, wb_pc,
           wb_csr_op, wb_csr_result, wb_exc
  );
endinterface

// File: rtl/m2_stage_load_align.sv
// Load data lane select plus sign/zero extension and alignment check.
module load_align
  import risc_pipe_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        misaligned
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{offset, 3'b000} +: 8];
  assign half_v = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    data       = rdata;
    misaligned = 1'b0;
    case (funct3)
      MEM_LB:  data = {{24{byte_v[7]}}, byte_v};
      MEM_LBU: data = {24'd0, byte_v};
      MEM_LH: begin
        data       = {{16{half_v[15]}}, half_v};
        misaligned = offset[0];
      end
      MEM_LHU: begin
        data       = {16'd0, half_v};
        misaligned = offset[0];
      end
      MEM_LW:  misaligned = (offset != 2'b00);
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/m2_stage.sv
// Second memory stage: completes loads, selects the writeback value, registers M2->WB,
// stalls the front of the pipe while a load response is outstanding.
module m2_stage
  import risc_pipe_pkg::*;
#(
  parameter int RSP_TIMEOUT = 16
) (
  input logic        clk,
  input logic        nrst,
  m2_stage_if.slave  bus
);
  localparam int CW = $clog2(RSP_TIMEOUT) + 1;

  m2_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] ld_data, sel_data;
  logic        ld_mis, is_load, is_store, mis_load, aln_load, bubble_in, timeout;
  logic        ret, we_n;
  logic [1:0]  exc;

  load_align u_align (
    .funct3     (bus.mem_op[2:0]),
    .offset     (bus.result[1:0]),
    .rdata      (bus.dmem_rdata),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  assign is_load   = bus.mem_op[4];
  assign is_store  = bus.mem_op[3] && !bus.mem_op[4];
  assign mis_load  = is_load && ld_mis;
  assign aln_load  = is_load && !ld_mis;
  assign bubble_in = (bus.wb_src == WB_NONE) && (bus.mem_op == 5'd0) && (bus.csr_op == 16'd0);
  assign timeout   = (state == ST_WAIT) && (cnt == CW'(RSP_TIMEOUT - 1));

  always_comb begin
    sel_data = 32'd0;
    case (bus.wb_src)
      WB_ALU:  sel_data = bus.result;
      WB_LOAD: sel_data = ld_data;
      WB_PC4:  sel_data = bus.pc + 32'd4;
      WB_CSR:  sel_data = bus.csr_dataout;
      default: sel_data = 32'd0;
    endcase
  end

  // flush wins over every retire path; a killed load with its response still
  // in flight sends us to DRAIN so the orphan response is swallowed
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bus.stall = 1'b0;
    ret       = 1'b0;
    exc       = EXC_NONE;
    case (state)
      ST_RUN: begin
        if (bus.flush) begin
          if (aln_load && !bus.dmem_rvalid) state_n = ST_DRAIN;
        end else if (aln_load && !bus.dmem_rvalid) begin
          bus.stall = 1'b1;
          state_n   = ST_WAIT;
          cnt_n     = '0;
        end else begin
          ret = !bubble_in;
          if (mis_load)                       exc = EXC_MIS;
          else if (aln_load && bus.dmem_rerr) exc = EXC_FAULT;
        end
      end
      ST_WAIT: begin
        if (bus.flush) begin
          state_n = bus.dmem_rvalid ? ST_RUN : ST_DRAIN;
          cnt_n   = '0;
        end else if (bus.dmem_rvalid) begin
          ret     = 1'b1;
          exc     = bus.dmem_rerr ? EXC_FAULT : EXC_NONE;
          state_n = ST_RUN;
          cnt_n   = '0;
        end else if (timeout) begin
          ret     = 1'b1;
          exc     = EXC_FAULT;
          state_n = ST_DRAIN;
          cnt_n   = '0;
        end else begin
          bus.stall = 1'b1;
          cnt_n     = cnt + CW'(1);
        end
      end
      ST_DRAIN: begin
        bus.stall = 1'b1;
        if (bus.dmem_rvalid) state_n = ST_RUN;
      end
      default: state_n = ST_RUN;
    endcase
  end

  assign we_n = ret && (bus.wb_src != WB_NONE) && (bus.rd != 5'd0) && (exc == EXC_NONE) && !is_store;

  assign bus.fwd_valid = (state != ST_DRAIN) &&
                         ((bus.wb_src == WB_ALU) || (bus.wb_src == WB_PC4) || (bus.wb_src == WB_CSR) ||
                          (aln_load && bus.dmem_rvalid && !bus.dmem_rerr));
  assign bus.fwd_rd    = bus.rd;
  assign bus.fwd_data  = sel_data;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state             <= ST_RUN;
      cnt               <= '0;
      bus.wb_valid      <= 1'b0;
      bus.wb_we         <= 1'b0;
      bus.wb_rd         <= 5'd0;
      bus.wb_data       <= 32'd0;
      bus.wb_pc         <= 32'd0;
      bus.wb_csr_op     <= 16'd0;
      bus.wb_csr_result <= 32'd0;
      bus.wb_exc        <= EXC_NONE;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      bus.wb_valid      <= ret;
      bus.wb_we         <= we_n;
      bus.wb_rd         <= ret ? bus.rd : 5'd0;
      bus.wb_data       <= ret ? sel_data : 32'd0;
      bus.wb_pc         <= ret ? bus.pc : 32'd0;
      bus.wb_csr_op     <= ret ? bus.csr_op : 16'd0;
      bus.wb_csr_result <= ret ? bus.csr_result : 32'd0;
      bus.wb_exc        <= ret ? exc : EXC_NONE;
    end
  end
endmodule

// File: tb/tb_m2_stage.sv
// Directed bench for m2_stage: loads, waits, faults, flush/drain, timeout, pass-through.
module tb_m2_stage;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  m2_stage_if bus();
  m2_stage #(.RSP_TIMEOUT(16)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] res, input logic [4:0] rd, input logic [2:0] src,
                       input logic [31:0] pc, input logic [4:0] mop);
    bus.result = res; bus.rd = rd; bus.wb_src = src; bus.pc = pc; bus.mem_op = mop;
    bus.csr_op = 16'd0; bus.csr_dataout = 32'd0; bus.csr_result = 32'd0; bus.flush = 1'b0;
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'd0; bus.dmem_rerr = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    drive(32'h11, 5'd1, 3'd1, 32'h0, 5'd0);
    step(); step();
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%h exp=0", bus.wb_valid); end checks++;
    if (bus.wb_data !== 32'd0) begin errors++; $display("FAIL rst_data got=%h exp=0", bus.wb_data); end checks++;
    drive(32'h0, 5'd0, 3'd0, 32'h0, 5'd0);
    #1;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%h exp=0", bus.stall); end checks++;
    if (bus.fwd_valid !== 1'b0) begin errors++; $display("FAIL rst_fwd got=%h exp=0", bus.fwd_valid); end checks++;
    step();
    nrst = 1'b1;
  endtask

  task automatic test_lw_zero_wait();
    drive(32'h100, 5'd5, 3'd2, 32'h40, 5'b10010);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hDEADBEEF;
    #1;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL lw0_stall got=%h exp=0", bus.stall); end checks++;
    if (bus.fwd_valid !== 1'b1 || bus.fwd_data !== 32'hDEADBEEF)
      begin errors++; $display("FAIL lw0_fwd got=%h/%h exp=1/deadbeef", bus.fwd_valid, bus.fwd_data); end checks++;
    step();
    if (bus.wb_valid !== 1'b1 || bus.wb_we !== 1'b1 || bus.wb_data !== 32'hDEADBEEF || bus.wb_rd !== 5'd5)
      begin errors++; $display("FAIL lw0_wb got=%h/%h/%h/%h exp=1/1/deadbeef/05", bus.wb_valid, bus.wb_we, bus.wb_data, bus.wb_rd); end checks++;
    drive(32'h0, 5'd0, 3'd0, 32'h0, 5'd0);
    step();
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got=%h exp=0", bus.wb_valid); end checks++;
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3  [4];
    logic [31:0] adr [4];
    logic [31:0] exp [4];
    f3[0] = 3'b000; adr[0] = 32'h103; exp[0] = 32'hFFFFFF80;
    f3[1] = 3'b100; adr[1] = 32'h103; exp[1] = 32'h00000080;
    f3[2] = 3'b101; adr[2] = 32'h102; exp[2] = 32'h000080FF;
    f3[3] = 3'b001; adr[3] = 32'h102; exp[3] = 32'hFFFF80FF;
    for (int i = 0; i < 4; i++) begin
      drive(adr[i], 5'd6, 3'd2, 32'h80, {2'b10, f3[i]});
      bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h80FFFFFF;
      step();
      if (bus.wb_data !== exp[i] || bus.wb_we !== 1'b1)
        begin errors++; $display("FAIL ext%0d got=%h we=%h exp=%h we=1", i, bus.wb_data, bus.wb_we, exp[i]); end checks++;
    end
    drive(32'h0, 5'd0, 3'd0, 32'h0, 5'd0);
    step();
  endtask

  task automatic test_wait3();
    drive(32'h200, 5'd8, 3'd2, 32'hC0, 5'b10010);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.stall !== 1'b1) begin errors++; $display("FAIL w3_stall%0d got=%h exp=1", i, bus.stall); end checks++;
      step();
      if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL w3_bub%0d got=%h exp=0", i, bus.wb_valid); end checks++;
    end
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h12345678;
    #1;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL w3_rel got=%h exp=0", bus.stall); end checks++;
    step();
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h12345678 || bus.wb_pc !== 32'hC0)
      begin errors++; $display("FAIL w3_ret got=%h/%h/%h exp=1/12345678/c0", bus.wb_valid, bus.wb_data, bus.wb_pc); end checks++;
    drive(32'h0, 5'd0, 3'd0, 32'h0, 5'd0);
    step();
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL w3_once got=%h exp=0", bus.wb_valid); end checks++;
  endtask

  task automatic test_faults();
    drive(32'h101, 5'd4, 3'd2, 32'h10, 5'b10001);
    #1;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL mis_stall got=%h exp=0", bus.stall); end checks++;
    step();
    if (bus.wb_valid !== 1'b1 || bus.wb_exc !== 2'd1 || bus.wb_we !== 1'b0)
      begin errors++; $display("FAIL mis_lh got=%h/%h/%h exp=1/1/0", bus.wb_valid, bus.wb_exc, bus.wb_we); end checks++;
    drive(32'h102, 5'd4, 3'd2, 32'h14, 5'b10010);
    step();
    if (bus.wb_exc !== 2'd1 || bus.wb_we !== 1'b0)
      begin errors++; $display("FAIL mis_lw got=%h/%h exp=1/0", bus.wb_exc, bus.wb_we); end checks++;
    drive(32'h100, 5'd4, 3'd2, 32'h18, 5'b10010);
    bus.dmem_rvalid = 1'b1; bus.dmem_rerr = 1'b1;
    #1;
    if (bus.fwd_valid !== 1'b0) begin errors++; $display("FAIL rerr_fwd got=%h exp=0", bus.fwd_valid); end checks++;
    step();
    if (bus.wb_valid !== 1'b1 || bus.wb_exc !== 2'd2 || bus.wb_we !== 1'b0)
      begin errors++; $display("FAIL rerr got=%h/%h/%h exp=1/2/0", bus.wb_valid, bus.wb_exc, bus.wb_we); end checks++;
    drive(32'h0, 5'd0, 3'd0, 32'h0, 5'd0);
    step();
  endtask

  task automatic test_flush_wait();
    drive(32'h300, 5'd9, 3'd2, 32'h20, 5'b10010);
    step();
    #1;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL fl_wait got=%h exp=1", bus.stall); end checks++;
    bus.flush = 1'b1;
    step();
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL fl_kill got=%h exp=0", bus.wb_valid); end checks++;
    drive(32'h55, 5'd7, 3'd1, 32'h24, 5'd0);
    #1;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL fl_drain got=%h exp=1", bus.stall); end checks++;
    step();
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h0BAD0BAD;
    #1;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL fl_orph got=%h exp=1", bus.stall); end checks++;
    step();
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL fl_noret got=%h exp=0", bus.wb_valid); end checks++;
    bus.dmem_rvalid = 1'b0;
    #1;
    if (bus.stall !== 1'b0 || bus.fwd_valid !== 1'b1)
      begin errors++; $display("FAIL fl_run got=%h/%h exp=0/1", bus.stall, bus.fwd_valid); end checks++;
    step();
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h55 || bus.wb_rd !== 5'd7 || bus.wb_we !== 1'b1)
      begin errors++; $display("FAIL fl_next got=%h/%h/%h/%h exp=1/55/07/1", bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_we); end checks++;
  endtask

  task automatic test_timeout();
    int stalls = 0;
    int bubs = 0;
    drive(32'h400, 5'd3, 3'd2, 32'h30, 5'b10010);
    for (int i = 0; i < 16; i++) begin
      #1;
      if (bus.stall === 1'b1) stalls++;
      step();
      if (bus.wb_valid === 1'b0) bubs++;
    end
    if (stalls !== 16 || bubs !== 16) begin errors++; $display("FAIL to_stalls got=%0d/%0d exp=16/16", stalls, bubs); end checks++;
    #1;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL to_rel got=%h exp=0", bus.stall); end checks++;
    step();
    if (bus.wb_valid !== 1'b1 || bus.wb_exc !== 2'd2 || bus.wb_we !== 1'b0)
      begin errors++; $display("FAIL to_ret got=%h/%h/%h exp=1/2/0", bus.wb_valid, bus.wb_exc, bus.wb_we); end checks++;
    drive(32'h0, 5'd1, 3'd3, 32'hFFFFFFFC, 5'd0);
    #1;
    if (bus.stall !== 1'b1 || bus.fwd_valid !== 1'b0)
      begin errors++; $display("FAIL to_drain got=%h/%h exp=1/0", bus.stall, bus.fwd_valid); end checks++;
    step();
    bus.dmem_rvalid = 1'b1;
    step();
    bus.dmem_rvalid = 1'b0;
    #1;
    if (bus.fwd_valid !== 1'b1 || bus.fwd_data !== 32'h0)
      begin errors++; $display("FAIL jal_fwd got=%h/%h exp=1/0", bus.fwd_valid, bus.fwd_data); end checks++;
    step();
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0 || bus.wb_we !== 1'b1)
      begin errors++; $display("FAIL jal_wb got=%h/%h/%h exp=1/0/1", bus.wb_valid, bus.wb_data, bus.wb_we); end checks++;
  endtask

  task automatic test_misc();
    drive(32'h500, 5'd0, 3'd0, 32'h50, 5'b01010);
    #1;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL st_stall got=%h exp=0", bus.stall); end checks++;
    step();
    if (bus.wb_valid !== 1'b1 || bus.wb_we !== 1'b0)
      begin errors++; $display("FAIL st_wb got=%h/%h exp=1/0", bus.wb_valid, bus.wb_we); end checks++;
    drive(32'h0, 5'd9, 3'd4, 32'h54, 5'd0);
    bus.csr_op = 16'h0011; bus.csr_dataout = 32'hAA; bus.csr_result = 32'hBB;
    step();
    if (bus.wb_data !== 32'hAA || bus.wb_csr_op !== 16'h0011 || bus.wb_csr_result !== 32'hBB || bus.wb_we !== 1'b1)
      begin errors++; $display("FAIL csr got=%h/%h/%h/%h exp=aa/0011/bb/1", bus.wb_data, bus.wb_csr_op, bus.wb_csr_result, bus.wb_we); end checks++;
    drive(32'h77, 5'd0, 3'd1, 32'h58, 5'd0);
    step();
    if (bus.wb_valid !== 1'b1 || bus.wb_we !== 1'b0)
      begin errors++; $display("FAIL rd0 got=%h/%h exp=1/0", bus.wb_valid, bus.wb_we); end checks++;
    drive(32'h78, 5'd2, 3'd1, 32'h5C, 5'd0);
    bus.flush = 1'b1;
    step();
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL run_flush got=%h exp=0", bus.wb_valid); end checks++;
  endtask

  task automatic test_reset_in_wait();
    drive(32'h600, 5'd3, 3'd2, 32'h60, 5'b10010);
    step();
    nrst = 1'b0;
    step();
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rstw_valid got=%h exp=0", bus.wb_valid); end checks++;
    nrst = 1'b1;
    drive(32'h99, 5'd12, 3'd1, 32'h64, 5'd0);
    #1;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL rstw_run got=%h exp=0", bus.stall); end checks++;
    step();
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h99)
      begin errors++; $display("FAIL rstw_next got=%h/%h exp=1/99", bus.wb_valid, bus.wb_data); end checks++;
  endtask

  task automatic test_back_to_back();
    drive(32'hA1, 5'd10, 3'd1, 32'h70, 5'd0);
    step();
    if (bus.wb_data !== 32'hA1) begin errors++; $display("FAIL b2b_0 got=%h exp=a1", bus.wb_data); end checks++;
    drive(32'h104, 5'd11, 3'd2, 32'h74, 5'b10010);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
    step();
    if (bus.wb_data !== 32'hCAFEF00D || bus.wb_rd !== 5'd11)
      begin errors++; $display("FAIL b2b_1 got=%h/%h exp=cafef00d/0b", bus.wb_data, bus.wb_rd); end checks++;
    drive(32'hA3, 5'd12, 3'd3, 32'h78, 5'd0);
    step();
    if (bus.wb_data !== 32'h7C || bus.wb_pc !== 32'h78)
      begin errors++; $display("FAIL b2b_2 got=%h/%h exp=7c/78", bus.wb_data, bus.wb_pc); end checks++;
    drive(32'h0, 5'd0, 3'd0, 32'h0, 5'd0);
    step();
  endtask

  initial begin
    test_reset();
    test_lw_zero_wait();
    test_load_ext();
    test_wait3();
    test_faults();
    test_flush_wait();
    test_timeout();
    test_misc();
    test_reset_in_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
